mpadd_seq: RTL and testbench

- Multi-precision add sequencer. Accepts NWORDS×16-bit operands over a valid/ready handshake.
- Time-multiplexes one rca16cla (16-bit CLA) instance over the 16-bit slices, least-significant slice first, registering the carry between cycles.
- Returns the full-width sum, carry-out and signed overflow over a valid/ready handshake.
- Sits between the operand register file and the writeback stage of the arithmetic datapath.

---
 rtl/mpadd_pkg.sv | 8 +
 rtl/rca16cla.sv | 26 ++
 rtl/mpadd_seq.sv | 91 +++++++++
 tb/tb_mpadd_seq.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mpadd_pkg.sv
// mpadd_pkg: shared slice width, FSM states and index sizing for mpadd_seq
package mpadd_pkg;
    localparam int SLICE_W = 16;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rca16cla.sv
// rca16cla: 16-bit adder, four 4-bit lookahead groups with rippled group carry
module rca16cla (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [15:0] p, g;
    logic [16:0] c;
    assign p = a ^ b;
    assign g = a & b;
    assign c[0] = cin;
    for (genvar k = 0; k < 4; k++) begin : grp
        localparam int B = 4 * k;
        assign c[B+1] = g[B]   | (p[B]   & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B])   | (p[B+1] & p[B]   & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B])
                      | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
    end
    assign s    = p ^ c[15:0];
    assign cout = c[16];
endmodule

// File: rtl/mpadd_seq.sv
// mpadd_seq: multi-precision adder sequencing one 16-bit CLA over NWORDS slices, LSB first
// Optional MPADD_SUB_EN adds op_sub (A + ~B + cin).
module mpadd_seq
    import mpadd_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SLICE_W*NWORDS-1:0] op_a,
    input  logic [SLICE_W*NWORDS-1:0] op_b,
    input  logic                    cin,
`ifdef MPADD_SUB_EN
    input  logic                    op_sub,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SLICE_W*NWORDS-1:0] sum,
    output logic                    cout,
    output logic                    ovf,
    output logic                    busy
);
    localparam int DW = SLICE_W * NWORDS;
    localparam int IW = idx_width(NWORDS);
    state_t state, state_nxt;
    logic [DW-1:0] a_r, b_r;
    logic [IW-1:0] idx;
    logic carry, last;
    logic [SLICE_W-1:0] sa, sb, ss;
    logic sc;
    assign sa = a_r[SLICE_W*int'(idx) +: SLICE_W];
`ifdef MPADD_SUB_EN
    logic sub_r;
    assign sb = b_r[SLICE_W*int'(idx) +: SLICE_W] ^ {SLICE_W{sub_r}};
`else
    assign sb = b_r[SLICE_W*int'(idx) +: SLICE_W];
`endif
    assign last = int'(idx) == NWORDS - 1;
    rca16cla u_add (.a(sa), .b(sb), .cin(carry), .s(ss), .cout(sc));
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                a_r   <= op_a;
                b_r   <= op_b;
                idx   <= '0;
                carry <= cin;
            end
            if (state == RUN) begin
                sum[SLICE_W*int'(idx) +: SLICE_W] <= ss;
                carry <= sc;
                idx   <= last ? idx : idx + 1'b1;
                if (last) begin
                    cout <= sc;
                    ovf  <= sa[SLICE_W-1] ^ sb[SLICE_W-1] ^ ss[SLICE_W-1] ^ sc;
                end
            end
        end
    end
`ifdef MPADD_SUB_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sub_r <= 1'b0;
        else if (state == IDLE && in_valid)
            sub_r <= op_sub;
    end
`endif
endmodule

// File: tb/tb_mpadd_seq.sv
// tb_mpadd_seq: table-driven and sequence checks of mpadd_seq with NWORDS=4
module tb_mpadd_seq;
    localparam int DW = 64;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, cout, ovf, busy;
    logic [DW-1:0] op_a = '0, op_b = '0, sum;
`ifdef MPADD_SUB_EN
    logic op_sub = 1'b0;
`endif
    int passed = 0, total = 0;

    mpadd_seq #(.NWORDS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef MPADD_SUB_EN
        .op_sub(op_sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a, b;
        logic          c;
        logic [DW-1:0] s;
        logic          co, ov;
    } vec_t;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic accept(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c);
        @(negedge clk);
        op_a = a; op_b = b; cin = c; in_valid = 1'b1;
        check("in_ready_before_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, n, 4);
    endtask

    task automatic check_result(input string name, input vec_t v);
        check({name, "_sum"}, sum, v.s);
        check({name, "_cout"}, cout, v.co);
        check({name, "_ovf"}, ovf, v.ov);
    endtask

    vec_t tbl[5];
    vec_t bp;

    initial begin
        tbl[0] = '{64'h0000_0000_0000_AA2A, 64'h0000_0000_0000_CCCC, 1'b1, 64'h0000_0000_0001_76F7, 1'b0, 1'b0};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        tbl[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        tbl[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};

        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        out_ready = 1'b1;
        foreach (tbl[i]) begin
            accept(tbl[i].a, tbl[i].b, tbl[i].c);
            wait_done($sformatf("vec%0d", i));
            check_result($sformatf("vec%0d", i), tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d_drain_valid", i), out_valid, 0);
            check($sformatf("vec%0d_drain_ready", i), in_ready, 1);
        end

        out_ready = 1'b0;
        bp = tbl[4];
        accept(bp.a, bp.b, bp.c);
        wait_done("bp");
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            op_a = 64'hDEAD_BEEF_0000_0000 + 64'(k);
            @(negedge clk);
            check("bp_valid_held", out_valid, 1);
            check("bp_in_ready_low", in_ready, 0);
            check_result("bp_hold", bp);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        @(negedge clk);
        check("bp_second_not_taken", busy, 0);

        accept(tbl[1].a, tbl[1].b, tbl[1].c);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("midrst_no_valid", seen, 0);
        end
        accept(tbl[4].a, tbl[4].b, tbl[4].c);
        wait_done("post_rst");
        check_result("post_rst", tbl[4]);
        @(negedge clk);

`ifdef MPADD_SUB_EN
        op_sub = 1'b1;
        accept(64'd5, 64'd7, 1'b1);
        op_sub = 1'b0;
        wait_done("sub");
        check_result("sub", '{64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
